// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: stall/flush sequencer for the 5-stage RV32I pipeline.
// Merges the ID hazard stall, the EX redirect and LSU busy into per-stage
// enables/flushes, sequences the post-redirect fetch bubble and runs a
// memory watchdog. Optional performance counters: define PIPE_PERF_CNT_EN.
module pipeline_control_unit #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned PERF_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall_from_ID,
  input  logic              i_redirect_EX,
  input  logic              i_mem_busy,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_en,
  output logic              o_id_ex_flush,
  output logic              o_ex_mem_en,
  output logic              o_mem_wb_en,
  output logic              o_mem_timeout,
  output logic [PERF_W-1:0] o_stall_cycles,
  output logic [PERF_W-1:0] o_busy_cycles,
  output logic [PERF_W-1:0] o_flush_events
);

  localparam int unsigned     TO_W       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
  localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam bit              WD_EN      = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  state_t          ret_state, ret_state_nxt;
  state_t          eff_state;
  logic [2:0]      flush_cnt, flush_cnt_nxt;
  logic [TO_W-1:0] to_cnt;

  // While frozen, the sequence resumes from the state that was interrupted
  assign eff_state = (state == ST_MEM_WAIT) ? ret_state : state;

  // State register and redirect bubble counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next-state and zero-latency stage controls, in priority order
  always_comb begin
    state_nxt      = state;
    ret_state_nxt  = ret_state;
    flush_cnt_nxt  = flush_cnt;
    o_pc_en        = 1'b1;
    o_if_id_en     = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_en     = 1'b1;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_en    = 1'b1;
    o_mem_wb_en    = 1'b1;

    if (i_rst) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_en    = 1'b0;
      o_ex_mem_en   = 1'b0;
      o_mem_wb_en   = 1'b0;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      state_nxt     = ST_RUN;
    end else if (i_mem_busy) begin
      o_pc_en     = 1'b0;
      o_if_id_en  = 1'b0;
      o_id_ex_en  = 1'b0;
      o_ex_mem_en = 1'b0;
      o_mem_wb_en = 1'b0;
      if (state != ST_MEM_WAIT) begin
        ret_state_nxt = state;
        state_nxt     = ST_MEM_WAIT;
      end
    end else if (i_redirect_EX) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      flush_cnt_nxt = FLUSH_INIT;
      state_nxt     = (FLUSH_CYCLES != 0) ? ST_FLUSH : ST_RUN;
    end else if (eff_state == ST_FLUSH) begin
      o_if_id_flush = 1'b1;
      flush_cnt_nxt = flush_cnt - 3'd1;
      state_nxt     = (flush_cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
    end else if (i_stall_from_ID) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
      state_nxt     = ST_RUN;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  // Watchdog: counts consecutive busy cycles, flags a hung access (sticky)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt        <= '0;
      o_mem_timeout <= 1'b0;
    end else if (!i_mem_busy) begin
      to_cnt <= '0;
    end else begin
      if (to_cnt != {TO_W{1'b1}}) to_cnt <= to_cnt + TO_W'(1);
      if (WD_EN && (to_cnt == TO_LAST)) o_mem_timeout <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic perf_stall, perf_busy, perf_redir;

  assign perf_busy  = !i_rst && i_mem_busy;
  assign perf_redir = !i_rst && !i_mem_busy && i_redirect_EX;
  assign perf_stall = !i_rst && !i_mem_busy && !i_redirect_EX &&
                      (eff_state != ST_FLUSH) && i_stall_from_ID;

  // Saturating event counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cycles <= '0;
      o_busy_cycles  <= '0;
      o_flush_events <= '0;
    end else begin
      if (perf_stall && (o_stall_cycles != {PERF_W{1'b1}}))
        o_stall_cycles <= o_stall_cycles + PERF_W'(1);
      if (perf_busy && (o_busy_cycles != {PERF_W{1'b1}}))
        o_busy_cycles <= o_busy_cycles + PERF_W'(1);
      if (perf_redir && (o_flush_events != {PERF_W{1'b1}}))
        o_flush_events <= o_flush_events + PERF_W'(1);
    end
  end
`else
  assign o_stall_cycles = '0;
  assign o_busy_cycles  = '0;
  assign o_flush_events = '0;
`endif

endmodule
